sc_datamem_io: RTL and testbench
================================

SC_DATAMEM_IO -- requirements
Module: sc_datamem_io

Interface
REQ-001 Parameter DEPTH_LOG2, default 5, SHALL set RAM depth to 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter N_OUT, default 2 (range 1..8), SHALL set the number of 32-bit output ports.
REQ-003 Parameter N_IN, default 2 (range 1..8), SHALL set the number of input ports.
REQ-004 Parameter IN_W, default 8 (range 1..32), SHALL set the width of each input port.
REQ-005 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 addr  in  32  byte address; bit IO_BIT = DEPTH_LOG2+2 SHALL select I/O (1) or RAM (0).
REQ-008 datain  in  32  write data.
REQ-009 we  in  1  write strobe.
REQ-010 be  in  4  byte-lane enables; be[k] gates datain[8k+7:8k].
REQ-011 re  in  1  read strobe; only used for clear-on-read side effects.
REQ-012 dataout  out  32  read data.
REQ-013 out_port  out  N_OUT*32  output registers, port i at bits [32i+31:32i].
REQ-014 in_port  in  N_IN*IN_W  asynchronous external inputs, port i at bits [IN_W*i+IN_W-1:IN_W*i].

Function
REQ-015 RAM word index SHALL be addr[DEPTH_LOG2+1:2]; addr[1:0] and bits above IO_BIT SHALL be ignored.
REQ-016 RAM write SHALL occur at the rising edge when we=1 and addr[IO_BIT]=0, updating only lanes with be=1.
REQ-017 dataout SHALL be combinational from addr and current state (zero-cycle read), so a single-cycle CPU can load in the same cycle.
REQ-018 I/O word offset SHALL be addr[6:2]; map: 0..N_OUT-1 output reg i (R/W); 8..8+N_IN-1 synchronised input i (RO, zero-extended); 16 STATUS (RO, clear-on-read); 17 CYCLE counter (R/W).
REQ-019 Output reg write SHALL obey be per lane; out_port SHALL reflect the register directly (no extra delay).
REQ-020 Each input SHALL pass through a two-flop synchroniser; offset 8+i SHALL read the second flop (latency 2 clocks from in_port change).
REQ-021 STATUS bit i SHALL set when the synchronised input i differs from its value one clock earlier; bits N_IN..31 SHALL read 0.
REQ-022 STATUS SHALL clear at the rising edge when re=1, addr[IO_BIT]=1, offset=16; if a new change occurs in that same cycle, set SHALL win for that bit.
REQ-023 CYCLE SHALL increment by 1 every clock, wrapping 0xFFFFFFFF->0; a write SHALL load datain (per-lane be) instead of incrementing that cycle.
REQ-024 Reads of unmapped I/O offsets SHALL return 0; writes to them and to RO offsets SHALL be ignored.
REQ-025 we=1 with be=0000 SHALL change no state; re SHALL have no effect outside offset 16.

Reset
REQ-026 When reset=1 at a rising edge: out regs, STATUS, CYCLE and synchroniser flops SHALL become 0; we/re ignored that cycle.
REQ-027 RAM contents SHALL NOT be reset.
REQ-028 First clock after reset deasserts, CYCLE SHALL read 0 then increment; STATUS SHALL not set from the reset-to-first-sample transition of an input held at 0.

Structure
REQ-029 Shared package SHALL hold I/O offset constants (OUT_BASE=0, IN_BASE=8, STATUS_OFF=16, CYCLE_OFF=17) and the byte-merge function.
REQ-030 The per-input synchroniser plus change detector SHALL be one sub-module, io_in_sync, instantiated N_IN times.
REQ-031 RAM SHALL be an inferred register array inside the top module; no vendor macro.

Verification
REQ-032 Write 0xDEADBEEF to RAM 0x04 be=1111, then be=0010 data 0x0000AA00 -> read 0x04 returns 0xDEADAABE... corrected: 0xDEADAAEF.
REQ-033 Write 0x12345678 to I/O 0x80 -> out_port[31:0]=0x12345678 after that edge; read 0x80 returns same; out_port[63:32] stays 0.
REQ-034 Drive in_port[7:0]=0x5A -> read 0xA0 returns 0 for 1 clock, 0x0000005A from 2nd clock; STATUS (0xC0) bit0=1.
REQ-035 Read STATUS with re=1 while in_port1 changes to reach sync stage the same cycle -> bit0 clears, bit1 remains 1.
REQ-036 After reset, 10 clocks -> CYCLE (0xC4) reads 10; write 0xFFFFFFFF, 1 clock -> reads 0.
REQ-037 Assert reset mid-run with out reg =0x12345678 and STATUS=0x3 -> both read 0 next cycle; previously written RAM word unchanged.

Source files
------------

// File: rtl/sc_datamem_io_pkg.sv
// rtl/sc_datamem_io_pkg.sv - I/O offset map and byte-lane merge shared by the data memory and its I/O block
package sc_datamem_io_pkg;

  localparam int OUT_BASE   = 0;
  localparam int IN_BASE    = 8;
  localparam int STATUS_OFF = 16;
  localparam int CYCLE_OFF  = 17;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_datamem_io_in_sync.sv
// rtl/sc_datamem_io_in_sync.sv - two-flop synchroniser for one input port plus a change flag on the synced value
module io_in_sync #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] sync_o,
  output logic         change_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  // prev_q also resets to 0, so an input held at 0 never flags a change after reset
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o   = sync_q;
  assign change_o = (sync_q != prev_q);

endmodule

// File: rtl/sc_datamem_io.sv
// rtl/sc_datamem_io.sv - single-cycle data RAM with memory-mapped output, input, status and cycle registers
module sc_datamem_io
  import sc_datamem_io_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5,
  parameter int N_OUT      = 2,
  parameter int N_IN       = 2,
  parameter int IN_W       = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            addr,
  input  logic [31:0]            datain,
  input  logic                   we,
  input  logic [3:0]             be,
  input  logic                   re,
  output logic [31:0]            dataout,
  output logic [N_OUT*32-1:0]    out_port,
  input  logic [N_IN*IN_W-1:0]   in_port
);

  localparam int IO_BIT = DEPTH_LOG2 + 2;
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  logic                  is_io;
  logic [4:0]            io_off;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  ram_we;
  logic                  status_clr;
  logic                  unused_addr;

  assign is_io       = addr[IO_BIT];
  assign io_off      = addr[6:2];
  assign ram_idx     = addr[DEPTH_LOG2+1:2];
  assign ram_we      = we & ~is_io & ~reset;
  assign status_clr  = re & is_io & (io_off == 5'(STATUS_OFF));
  assign unused_addr = ^{addr[31:IO_BIT+1], addr[1:0]};

  logic [31:0]                mem_q [DEPTH];
  logic [N_OUT-1:0][31:0]     out_q, out_d;
  logic [N_IN-1:0]            status_q, status_d;
  logic [31:0]                cycle_q, cycle_d;
  logic [N_IN-1:0][IN_W-1:0]  in_sync;
  logic [N_IN-1:0]            in_chg;

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    io_in_sync #(.W(IN_W)) u_sync (
      .clock    (clock),
      .reset    (reset),
      .din_i    (in_port[IN_W*g +: IN_W]),
      .sync_o   (in_sync[g]),
      .change_o (in_chg[g])
    );
  end

  always_comb begin
    out_d = out_q;
    for (int i = 0; i < N_OUT; i++) begin
      if (we && is_io && io_off == 5'(OUT_BASE + i))
        out_d[i] = byte_merge(out_q[i], datain, be);
    end
    if (we && is_io && io_off == 5'(CYCLE_OFF) && be != 4'b0000)
      cycle_d = byte_merge(cycle_q, datain, be);
    else
      cycle_d = cycle_q + 32'd1;
    // A change arriving in the clearing cycle is ORed in after the clear, so it survives
    status_d = (status_clr ? '0 : status_q) | in_chg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q    <= '0;
      status_q <= '0;
      cycle_q  <= '0;
    end else begin
      out_q    <= out_d;
      status_q <= status_d;
      cycle_q  <= cycle_d;
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) mem_q[ram_idx] <= byte_merge(mem_q[ram_idx], datain, be);
  end

  always_comb begin
    dataout = '0;
    if (!is_io) begin
      dataout = mem_q[ram_idx];
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (io_off == 5'(OUT_BASE + i)) dataout = out_q[i];
      end
      for (int i = 0; i < N_IN; i++) begin
        if (io_off == 5'(IN_BASE + i)) dataout = 32'(in_sync[i]);
      end
      if (io_off == 5'(STATUS_OFF)) dataout = 32'(status_q);
      if (io_off == 5'(CYCLE_OFF))  dataout = cycle_q;
    end
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_sc_datamem_io.sv
// tb/tb_sc_datamem_io.sv - directed self-checking bench for sc_datamem_io
module tb_sc_datamem_io;

  logic        clock;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [3:0]  be;
  logic        re;
  logic [31:0] dataout;
  logic [63:0] out_port;
  logic [15:0] in_port;

  int passed;
  int total;

  sc_datamem_io dut (
    .clock    (clock),
    .reset    (reset),
    .addr     (addr),
    .datain   (datain),
    .we       (we),
    .be       (be),
    .re       (re),
    .dataout  (dataout),
    .out_port (out_port),
    .in_port  (in_port)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clock);
    addr = a; datain = d; be = b; we = 1'b1; re = 1'b0;
    @(negedge clock);
    we = 1'b0; be = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a; re = 1'b0;
    #1;
    v = dataout;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1; we = 1'b0; re = 1'b0; be = 4'h0; addr = '0; datain = '0; in_port = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    rd(32'hC4, v);
    total++; if (v !== 32'h0) $display("FAIL reset_cycle: got %h expected %h", v, 32'h0); else passed++;
    rd(32'hC0, v);
    total++; if (v !== 32'h0) $display("FAIL reset_status: got %h expected %h", v, 32'h0); else passed++;
    rd(32'h80, v);
    total++; if (v !== 32'h0) $display("FAIL reset_out0: got %h expected %h", v, 32'h0); else passed++;
    total++; if (out_port !== 64'h0) $display("FAIL reset_out_port: got %h expected %h", out_port, 64'h0); else passed++;
  endtask

  task automatic test_cycle;
    logic [31:0] v;
    repeat (10) @(negedge clock);
    rd(32'hC4, v);
    total++; if (v !== 32'd10) $display("FAIL cycle_after_10: got %h expected %h", v, 32'd10); else passed++;
    addr = 32'hC4; datain = 32'hFFFF_FFFF; be = 4'hF; we = 1'b1;
    @(negedge clock);
    we = 1'b0; be = 4'h0;
    rd(32'hC4, v);
    total++; if (v !== 32'hFFFF_FFFF) $display("FAIL cycle_load: got %h expected %h", v, 32'hFFFF_FFFF); else passed++;
    @(negedge clock);
    rd(32'hC4, v);
    total++; if (v !== 32'h0) $display("FAIL cycle_wrap: got %h expected %h", v, 32'h0); else passed++;
  endtask

  task automatic test_ram;
    logic [31:0] v;
    wr(32'h04, 32'hDEAD_BEEF, 4'hF);
    wr(32'h04, 32'h0000_AA00, 4'b0010);
    rd(32'h04, v);
    total++; if (v !== 32'hDEAD_AAEF) $display("FAIL ram_lane_merge: got %h expected %h", v, 32'hDEAD_AAEF); else passed++;
    rd(32'h107, v);
    total++; if (v !== 32'hDEAD_AAEF) $display("FAIL ram_alias: got %h expected %h", v, 32'hDEAD_AAEF); else passed++;
    wr(32'h7C, 32'hCAFE_F00D, 4'hF);
    wr(32'h7C, 32'h1111_1111, 4'h0);
    rd(32'h7C, v);
    total++; if (v !== 32'hCAFE_F00D) $display("FAIL ram_top_word_be0: got %h expected %h", v, 32'hCAFE_F00D); else passed++;
    rd(32'h04, v);
    total++; if (v !== 32'hDEAD_AAEF) $display("FAIL ram_other_word: got %h expected %h", v, 32'hDEAD_AAEF); else passed++;
  endtask

  task automatic test_out;
    logic [31:0] v;
    wr(32'h80, 32'h1234_5678, 4'hF);
    total++; if (out_port[31:0] !== 32'h1234_5678) $display("FAIL out0_port: got %h expected %h", out_port[31:0], 32'h1234_5678); else passed++;
    total++; if (out_port[63:32] !== 32'h0) $display("FAIL out1_untouched: got %h expected %h", out_port[63:32], 32'h0); else passed++;
    rd(32'h80, v);
    total++; if (v !== 32'h1234_5678) $display("FAIL out0_read: got %h expected %h", v, 32'h1234_5678); else passed++;
    wr(32'h84, 32'h00AB_0000, 4'b0100);
    total++; if (out_port[63:32] !== 32'h00AB_0000) $display("FAIL out1_lane: got %h expected %h", out_port[63:32], 32'h00AB_0000); else passed++;
    rd(32'h04, v);
    total++; if (v !== 32'hDEAD_AAEF) $display("FAIL io_write_hits_ram: got %h expected %h", v, 32'hDEAD_AAEF); else passed++;
    wr(32'h80, 32'hFFFF_FFFF, 4'h0);
    wr(32'h88, 32'h5555_5555, 4'hF);
    wr(32'hA0, 32'h7777_7777, 4'hF);
    total++; if (out_port !== 64'h00AB_0000_1234_5678) $display("FAIL out_ignored_writes: got %h expected %h", out_port, 64'h00AB_0000_1234_5678); else passed++;
    rd(32'h88, v);
    total++; if (v !== 32'h0) $display("FAIL unmapped_read: got %h expected %h", v, 32'h0); else passed++;
    rd(32'hA0, v);
    total++; if (v !== 32'h0) $display("FAIL ro_input_write: got %h expected %h", v, 32'h0); else passed++;
  endtask

  task automatic test_input;
    logic [31:0] v;
    @(negedge clock);
    in_port[7:0] = 8'h5A;
    @(negedge clock);
    rd(32'hA0, v);
    total++; if (v !== 32'h0) $display("FAIL in0_latency1: got %h expected %h", v, 32'h0); else passed++;
    @(negedge clock);
    rd(32'hA0, v);
    total++; if (v !== 32'h0000_005A) $display("FAIL in0_latency2: got %h expected %h", v, 32'h0000_005A); else passed++;
    rd(32'hC0, v);
    total++; if (v !== 32'h0) $display("FAIL status_not_yet: got %h expected %h", v, 32'h0); else passed++;
    @(negedge clock);
    rd(32'hC0, v);
    total++; if (v !== 32'h1) $display("FAIL status_bit0: got %h expected %h", v, 32'h1); else passed++;
    addr = 32'h80; re = 1'b1;
    @(negedge clock);
    re = 1'b0;
    rd(32'hC0, v);
    total++; if (v !== 32'h1) $display("FAIL re_other_offset: got %h expected %h", v, 32'h1); else passed++;
  endtask

  task automatic test_status_clear;
    logic [31:0] v;
    in_port[15:8] = 8'h33;
    @(negedge clock);
    @(negedge clock);
    addr = 32'hC0; re = 1'b1;
    #1;
    total++; if (dataout !== 32'h1) $display("FAIL status_before_clear: got %h expected %h", dataout, 32'h1); else passed++;
    @(negedge clock);
    re = 1'b0;
    rd(32'hC0, v);
    total++; if (v !== 32'h2) $display("FAIL status_clear_set_wins: got %h expected %h", v, 32'h2); else passed++;
    rd(32'hA4, v);
    total++; if (v !== 32'h0000_0033) $display("FAIL in1_read: got %h expected %h", v, 32'h0000_0033); else passed++;
    in_port[7:0] = 8'h5B;
    repeat (3) @(negedge clock);
    rd(32'hC0, v);
    total++; if (v !== 32'h3) $display("FAIL status_both: got %h expected %h", v, 32'h3); else passed++;
  endtask

  task automatic test_reset_midrun;
    logic [31:0] v;
    rd(32'h80, v);
    total++; if (v !== 32'h1234_5678) $display("FAIL pre_reset_out0: got %h expected %h", v, 32'h1234_5678); else passed++;
    reset = 1'b1;
    addr = 32'h04; datain = 32'h0; be = 4'hF; we = 1'b1;
    @(negedge clock);
    reset = 1'b0; we = 1'b0; be = 4'h0;
    rd(32'h80, v);
    total++; if (v !== 32'h0) $display("FAIL midreset_out0: got %h expected %h", v, 32'h0); else passed++;
    rd(32'hC0, v);
    total++; if (v !== 32'h0) $display("FAIL midreset_status: got %h expected %h", v, 32'h0); else passed++;
    rd(32'hC4, v);
    total++; if (v !== 32'h0) $display("FAIL midreset_cycle: got %h expected %h", v, 32'h0); else passed++;
    rd(32'hA0, v);
    total++; if (v !== 32'h0) $display("FAIL midreset_sync: got %h expected %h", v, 32'h0); else passed++;
    total++; if (out_port !== 64'h0) $display("FAIL midreset_out_port: got %h expected %h", out_port, 64'h0); else passed++;
    rd(32'h04, v);
    total++; if (v !== 32'hDEAD_AAEF) $display("FAIL ram_kept_04: got %h expected %h", v, 32'hDEAD_AAEF); else passed++;
    rd(32'h7C, v);
    total++; if (v !== 32'hCAFE_F00D) $display("FAIL ram_kept_7c: got %h expected %h", v, 32'hCAFE_F00D); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset;
    test_cycle;
    test_ram;
    test_out;
    test_input;
    test_status_clear;
    test_reset_midrun;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
